// File: rtl/asip_pkg.sv
// rtl/asip_pkg.sv - shared ASIP fetch-path widths, types and the FIFO entry struct
package asip_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 24;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  // One buffered fetch result: the instruction word tagged with its address
  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - flushable synchronous FIFO of fetch entries with occupancy count
module instr_fifo
  import asip_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  fetch_entry_t        mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                do_push;
  logic                do_pop;

  // Flush wins over everything; a pop is only honoured when something is stored
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  assign valid = (count != '0);
  assign head  = valid ? mem[rd_ptr] : '0;

  // Storage array needs no reset: the head is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - PC generation, ROM request tracking and prefetch buffering
module instr_prefetch
  import asip_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [PC_W-1:0]        rom_addr,
  input  logic [INSTR_W-1:0]     rom_data,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_W-1:0]        redirect_pc,
  output logic                   instr_valid,
  output logic [INSTR_W-1:0]     instr,
  output logic [PC_W-1:0]        instr_pc,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  inflight_pc;
  logic             inflight;
  logic [CNT_W:0]   occupancy;
  logic             issue;
  logic             push;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  // Credit check counts the outstanding ROM read so a return always has a slot
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign issue     = !redirect && (occupancy < (CNT_W + 1)'(DEPTH));

  // Returning data is dropped in a redirect cycle; no pop happens then either
  assign push       = inflight && !redirect;
  assign pop        = instr_valid && !stall && !redirect;
  assign push_entry = '{pc: inflight_pc, instr: rom_data};

  assign rom_addr = fetch_pc;
  assign instr    = head.instr;
  assign instr_pc = head.pc;

  // Fetch address and single outstanding-request tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else if (issue) begin
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
      fetch_pc    <= fetch_pc + 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .valid     (instr_valid),
    .count     (fifo_count)
  );

endmodule
